// File: rtl/mio_bus_responder_pkg.sv
// Shared RAMCtrl access codes, responder FSM states and the IO/RAM space select.
package mio_bus_responder_pkg;

    typedef enum logic [2:0] {
        CTRL_FULL   = 3'd0,
        CTRL_FULLX  = 3'd1,
        CTRL_HALF   = 3'd2,
        CTRL_HALFX  = 3'd3,
        CTRL_HALFU  = 3'd4,
        CTRL_HALFUX = 3'd5
    } ram_ctrl_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4,
        S_HOLD    = 3'd5
    } mio_state_t;

    localparam logic SPACE_IO = 1'b1;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mio_lane_format.sv
// Combinational store-lane placement and load extraction/extension for one RAMCtrl access.
// Shared by the RAM and IO paths; also reports natural-alignment violations.
module mio_lane_format
    import mio_bus_responder_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  st_we,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data,
    output logic        is_half,
    output logic        misaligned
);

    logic        swap;
    logic        sext;
    logic [15:0] st_hw;
    logic [15:0] ld_hw;
    logic [15:0] ld_lane;

    // Unsigned halfword codes only change loads; stores fall back to the signed form.
    always_comb begin
        is_half = 1'b0;
        swap    = 1'b0;
        sext    = 1'b0;
        case (ram_ctrl_t'(ctrl))
            CTRL_FULL:   ;
            CTRL_FULLX:  swap = 1'b1;
            CTRL_HALF:   begin is_half = 1'b1; sext = 1'b1; end
            CTRL_HALFX:  begin is_half = 1'b1; sext = 1'b1; swap = 1'b1; end
            CTRL_HALFU:  is_half = 1'b1;
            CTRL_HALFUX: begin is_half = 1'b1; swap = 1'b1; end
            default:     ;
        endcase
    end

    always_comb begin
        st_hw    = swap ? {st_data[7:0], st_data[15:8]} : st_data[15:0];
        ld_lane  = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        ld_hw    = swap ? {ld_lane[7:0], ld_lane[15:8]} : ld_lane;
        st_we    = 4'hF;
        st_lanes = swap ? bswap32(st_data) : st_data;
        ld_data  = swap ? bswap32(ld_raw) : ld_raw;
        if (is_half) begin
            st_we    = addr_lo[1] ? 4'hC : 4'h3;
            st_lanes = {st_hw, st_hw};
            ld_data  = sext ? {{16{ld_hw[15]}}, ld_hw} : {16'h0000, ld_hw};
        end
        misaligned = is_half ? addr_lo[0] : (addr_lo != 2'b00);
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO target for the CPU MemRead/MemWrite -> mio_ready handshake; latency WAIT_STATES+3.
// Holds off until the request level drops; optional MIO_ERR_EN flags misaligned accesses.
module mio_bus_responder
    import mio_bus_responder_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic              cpu_mio,
    input  logic [2:0]        ram_ctrl,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       data_from_cpu,
    output logic [31:0]       data_to_cpu,
    output logic              mio_ready,
    output logic              mio_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata
);

    mio_state_t  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_ctrl;
    logic        req_io;
    logic        req_wr;
    logic        req_err;

    logic [3:0]  fmt_we;
    logic [31:0] fmt_lanes;
    logic [31:0] fmt_ld;
    logic        fmt_half;
    logic        fmt_misaligned;
    logic        issue;

    mio_lane_format u_fmt (
        .ctrl       (req_ctrl),
        .addr_lo    (req_addr[1:0]),
        .st_data    (req_data),
        .ld_raw     ((req_io == SPACE_IO) ? io_rdata : ram_rdata),
        .st_we      (fmt_we),
        .st_lanes   (fmt_lanes),
        .ld_data    (fmt_ld),
        .is_half    (fmt_half),
        .misaligned (fmt_misaligned)
    );

`ifdef MIO_ERR_EN
    assign req_err = fmt_misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = fmt_misaligned;
    assign req_err           = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (mem_r || mem_w) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_ISSUE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_RESP;
            S_RESP:    state_nxt = S_HOLD;
            // A request level still held after completion must not be served twice.
            S_HOLD:    if (!mem_r && !mem_w) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr <= 32'h0;
            req_data <= 32'h0;
            req_ctrl <= 3'd0;
            req_io   <= 1'b0;
            req_wr   <= 1'b0;
        end else if (state == S_IDLE && (mem_r || mem_w)) begin
            req_addr <= addr_bus;
            req_data <= data_from_cpu;
            req_ctrl <= ram_ctrl;
            req_io   <= cpu_mio;
            req_wr   <= mem_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_to_cpu <= 32'h0;
        end else if (state == S_CAPTURE) begin
            if (req_err)     data_to_cpu <= 32'h0;
            else if (!req_wr) data_to_cpu <= fmt_ld;
        end
    end

    assign issue     = (state == S_ISSUE) && !req_err;
    assign ram_en    = issue && (req_io != SPACE_IO);
    assign ram_we    = (ram_en && req_wr) ? fmt_we : 4'h0;
    assign ram_addr  = req_addr[RAM_AW+1:2];
    assign ram_wdata = fmt_lanes;
    assign io_rd     = issue && (req_io == SPACE_IO) && !req_wr;
    assign io_wr     = issue && (req_io == SPACE_IO) && req_wr;
    assign io_addr   = fmt_half ? {req_addr[31:1], 1'b0} : {req_addr[31:2], 2'b00};
    assign io_wdata  = fmt_lanes;
    assign mio_ready = (state == S_RESP);
    assign mio_err   = (state == S_RESP) && req_err;

endmodule
